// File: rtl/md_unit.sv
// Multiply/divide unit feeding architectural HI/LO. Results are computed at issue
// and held in pending registers while a countdown models the configured latency.
module md_unit #(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cut,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dz,
  output logic             state_o
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MSUB  = 3'd7;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   p_hi_q, p_hi_d, p_lo_q, p_lo_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               dz_q, dz_d;
  logic               issue;

  logic [2*WIDTH-1:0] a_sx, b_sx, a_zx, b_zx, prod_s, prod_u, acc;
  logic               b_zero;
  logic [WIDTH-1:0]   a_mag, b_mag, den_u, den_s;
  logic [WIDTH-1:0]   q_u, r_u, q_mag, r_mag, q_s, r_s;

  assign issue  = start & ~cut & (state_q == IDLE);

  assign a_sx   = {{WIDTH{a[WIDTH-1]}}, a};
  assign b_sx   = {{WIDTH{b[WIDTH-1]}}, b};
  assign a_zx   = {{WIDTH{1'b0}}, a};
  assign b_zx   = {{WIDTH{1'b0}}, b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = a_zx * b_zx;
  assign acc    = {hi_q, lo_q};

  // Signed divide works on magnitudes; most-negative / -1 wraps back to most-negative.
  assign b_zero = (b == '0);
  assign a_mag  = a[WIDTH-1] ? -a : a;
  assign b_mag  = b[WIDTH-1] ? -b : b;
  assign den_u  = b_zero ? WIDTH'(1) : b;
  assign den_s  = b_zero ? WIDTH'(1) : b_mag;
  assign q_u    = a / den_u;
  assign r_u    = a % den_u;
  assign q_mag  = a_mag / den_s;
  assign r_mag  = a_mag % den_s;
  assign q_s    = (a[WIDTH-1] ^ b[WIDTH-1]) ? -q_mag : q_mag;
  assign r_s    = a[WIDTH-1] ? -r_mag : r_mag;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_hi_d  = p_hi_q;
    p_lo_d  = p_lo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (issue) begin
          case (op)
            OP_MULT: begin
              {p_hi_d, p_lo_d} = prod_s;
              cnt_d   = CW'(MULT_LAT);
              state_d = RUN;
            end
            OP_MULTU: begin
              {p_hi_d, p_lo_d} = prod_u;
              cnt_d   = CW'(MULT_LAT);
              state_d = RUN;
            end
            OP_MADD: begin
              {p_hi_d, p_lo_d} = acc + prod_s;
              cnt_d   = CW'(MULT_LAT);
              state_d = RUN;
            end
            OP_MSUB: begin
              {p_hi_d, p_lo_d} = acc - prod_s;
              cnt_d   = CW'(MULT_LAT);
              state_d = RUN;
            end
            OP_DIV: begin
              if (b_zero) begin
                p_hi_d = a;
                p_lo_d = {WIDTH{1'b1}};
                dz_d   = 1'b1;
              end else begin
                p_hi_d = r_s;
                p_lo_d = q_s;
              end
              cnt_d   = CW'(DIV_LAT);
              state_d = RUN;
            end
            OP_DIVU: begin
              if (b_zero) begin
                p_hi_d = a;
                p_lo_d = {WIDTH{1'b1}};
                dz_d   = 1'b1;
              end else begin
                p_hi_d = r_u;
                p_lo_d = q_u;
              end
              cnt_d   = CW'(DIV_LAT);
              state_d = RUN;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
          endcase
        end
      end
      RUN: begin
        // Commit on the last busy cycle so HI/LO never show a partial result.
        if (cnt_q == CW'(1)) begin
          hi_d    = p_hi_q;
          lo_d    = p_lo_q;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_hi_q  <= '0;
      p_lo_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_hi_q  <= p_hi_d;
      p_lo_q  <= p_lo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign dz      = dz_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: default 32-bit instance plus a 16-bit, 1-cycle instance.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_md_unit;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MSUB  = 3'd7;

  logic        clk, reset, start, cut;
  logic [2:0]  op;
  logic [31:0] a, b, hi, lo;
  logic        busy, dz, state;

  logic        s_start, s_cut;
  logic [2:0]  s_op;
  logic [15:0] s_a, s_b, s_hi, s_lo;
  logic        s_busy, s_dz, s_state;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_hi, m_lo;

  md_unit #(.WIDTH(32), .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) u_dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .cut(cut),
    .busy(busy), .hi(hi), .lo(lo), .dz(dz), .state_o(state)
  );

  md_unit #(.WIDTH(16), .MULT_LAT(1), .DIV_LAT(1)) u_small (
    .clk(clk), .reset(reset), .start(s_start), .op(s_op), .a(s_a), .b(s_b), .cut(s_cut),
    .busy(s_busy), .hi(s_hi), .lo(s_lo), .dz(s_dz), .state_o(s_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a falling edge; drives one issue cycle and returns at the next falling edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic c);
    op = o; a = x; b = y; cut = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cut = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1)); cut = 1'($urandom_range(0, 1));
      op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
      n_checks++;
      if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || dz !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold: hi=%h lo=%h busy=%b dz=%b expected all zero", hi, lo, busy, dz);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    m_hi = 32'h0; m_lo = 32'h0;
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'h2, 1'b0);
    for (int k = 1; k <= MULT_LAT; k++) begin
      n_checks++;
      if (busy !== 1'b1 || hi !== m_hi || lo !== m_lo) begin
        n_fail++;
        $display("FAIL multu_run k=%0d: busy=%b hi=%h lo=%h expected busy=1 hi=%h lo=%h", k, busy, hi, lo, m_hi, m_lo);
      end
      @(negedge clk);
    end
    m_hi = 32'h0000_0001; m_lo = 32'hFFFF_FFFE;
    n_checks++;
    if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo || dz !== 1'b0) begin
      n_fail++;
      $display("FAIL multu_done: busy=%b hi=%h lo=%h dz=%b expected busy=0 hi=%h lo=%h dz=0", busy, hi, lo, dz, m_hi, m_lo);
    end
  endtask

  task automatic test_signed;
    logic [2:0]  ops [3];
    logic [31:0] xa [3], xb [3], eh [3], el [3];
    int          lat [3];
    ops[0] = OP_MULT; xa[0] = 32'hFFFF_FFFF; xb[0] = 32'h2;        eh[0] = 32'hFFFF_FFFF; el[0] = 32'hFFFF_FFFE; lat[0] = MULT_LAT;
    ops[1] = OP_DIV;  xa[1] = 32'hFFFF_FFF9; xb[1] = 32'h2;        eh[1] = 32'hFFFF_FFFF; el[1] = 32'hFFFF_FFFD; lat[1] = DIV_LAT;
    ops[2] = OP_DIV;  xa[2] = 32'h8000_0000; xb[2] = 32'hFFFF_FFFF; eh[2] = 32'h0;         el[2] = 32'h8000_0000; lat[2] = DIV_LAT;
    for (int t = 0; t < 3; t++) begin
      issue(ops[t], xa[t], xb[t], 1'b0);
      for (int k = 1; k <= lat[t]; k++) begin
        n_checks++;
        if (busy !== 1'b1 || hi !== m_hi || lo !== m_lo) begin
          n_fail++;
          $display("FAIL signed_run t=%0d k=%0d: busy=%b hi=%h lo=%h expected busy=1 hi=%h lo=%h", t, k, busy, hi, lo, m_hi, m_lo);
        end
        @(negedge clk);
      end
      m_hi = eh[t]; m_lo = el[t];
      n_checks++;
      if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo || dz !== 1'b0) begin
        n_fail++;
        $display("FAIL signed_done t=%0d: busy=%b hi=%h lo=%h dz=%b expected busy=0 hi=%h lo=%h dz=0", t, busy, hi, lo, dz, m_hi, m_lo);
      end
    end
  endtask

  task automatic test_cut;
    issue(OP_MULT, 32'h5, 32'h7, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      n_checks++;
      if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
        n_fail++;
        $display("FAIL cut_issue k=%0d: busy=%b hi=%h lo=%h expected busy=0 hi=%h lo=%h", k, busy, hi, lo, m_hi, m_lo);
      end
      @(negedge clk);
    end
    issue(OP_MTLO, 32'h1234, 32'h0, 1'b1);
    n_checks++;
    if (lo !== m_lo) begin
      n_fail++;
      $display("FAIL cut_mtlo: lo=%h expected %h", lo, m_lo);
    end
    issue(OP_MULTU, 32'h3, 32'h5, 1'b0);
    for (int k = 1; k <= MULT_LAT; k++) begin
      n_checks++;
      if (busy !== 1'b1 || hi !== m_hi || lo !== m_lo) begin
        n_fail++;
        $display("FAIL cut_run k=%0d: busy=%b hi=%h lo=%h expected busy=1 hi=%h lo=%h", k, busy, hi, lo, m_hi, m_lo);
      end
      cut = (k == 2);
      @(negedge clk);
    end
    cut = 1'b0;
    m_hi = 32'h0; m_lo = 32'hF;
    n_checks++;
    if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
      n_fail++;
      $display("FAIL cut_done: busy=%b hi=%h lo=%h expected busy=0 hi=%h lo=%h", busy, hi, lo, m_hi, m_lo);
    end
    issue(OP_MULT, 32'h2, 32'h3, 1'b0);
    for (int k = 1; k <= MULT_LAT; k++) begin
      n_checks++;
      if (busy !== 1'b1 || hi !== m_hi || lo !== m_lo) begin
        n_fail++;
        $display("FAIL start_busy_run k=%0d: busy=%b hi=%h lo=%h expected busy=1 hi=%h lo=%h", k, busy, hi, lo, m_hi, m_lo);
      end
      if (k == 2) begin
        op = OP_MTLO; a = 32'h1234; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    m_hi = 32'h0; m_lo = 32'h6;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
        n_fail++;
        $display("FAIL start_busy_done k=%0d: busy=%b hi=%h lo=%h expected busy=0 hi=%h lo=%h", k, busy, hi, lo, m_hi, m_lo);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    issue(OP_MULTU, 32'h0001_0000, 32'h0001_0000, 1'b0);
    repeat (MULT_LAT) @(negedge clk);
    m_hi = 32'h1; m_lo = 32'h0;
    n_checks++;
    if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
      n_fail++;
      $display("FAIL b2b_first: busy=%b hi=%h lo=%h expected busy=0 hi=%h lo=%h", busy, hi, lo, m_hi, m_lo);
    end
    issue(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    for (int k = 1; k <= MULT_LAT; k++) begin
      n_checks++;
      if (busy !== 1'b1 || hi !== m_hi || lo !== m_lo) begin
        n_fail++;
        $display("FAIL b2b_run k=%0d: busy=%b hi=%h lo=%h expected busy=1 hi=%h lo=%h", k, busy, hi, lo, m_hi, m_lo);
      end
      @(negedge clk);
    end
    m_hi = 32'h0; m_lo = 32'h1;
    n_checks++;
    if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
      n_fail++;
      $display("FAIL b2b_second: busy=%b hi=%h lo=%h expected busy=0 hi=%h lo=%h", busy, hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic test_accumulate;
    logic [2:0]  ops [3];
    logic [31:0] xa [3], xb [3], eh [3], el [3];
    issue(OP_MTHI, 32'h0, 32'h0, 1'b0);
    m_hi = 32'h0;
    n_checks++;
    if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
      n_fail++;
      $display("FAIL mthi: busy=%b hi=%h lo=%h expected busy=0 hi=%h lo=%h", busy, hi, lo, m_hi, m_lo);
    end
    issue(OP_MTLO, 32'hFFFF_FFFF, 32'h0, 1'b0);
    m_lo = 32'hFFFF_FFFF;
    n_checks++;
    if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
      n_fail++;
      $display("FAIL mtlo: busy=%b hi=%h lo=%h expected busy=0 hi=%h lo=%h", busy, hi, lo, m_hi, m_lo);
    end
    ops[0] = OP_MADD; xa[0] = 32'h1;         xb[0] = 32'h1; eh[0] = 32'h1; el[0] = 32'h0;
    ops[1] = OP_MSUB; xa[1] = 32'h1;         xb[1] = 32'h1; eh[1] = 32'h0; el[1] = 32'hFFFF_FFFF;
    ops[2] = OP_MADD; xa[2] = 32'hFFFF_FFFF; xb[2] = 32'h3; eh[2] = 32'h0; el[2] = 32'hFFFF_FFFC;
    for (int t = 0; t < 3; t++) begin
      issue(ops[t], xa[t], xb[t], 1'b0);
      for (int k = 1; k <= MULT_LAT; k++) begin
        n_checks++;
        if (busy !== 1'b1 || hi !== m_hi || lo !== m_lo) begin
          n_fail++;
          $display("FAIL acc_run t=%0d k=%0d: busy=%b hi=%h lo=%h expected busy=1 hi=%h lo=%h", t, k, busy, hi, lo, m_hi, m_lo);
        end
        @(negedge clk);
      end
      m_hi = eh[t]; m_lo = el[t];
      n_checks++;
      if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
        n_fail++;
        $display("FAIL acc_done t=%0d: busy=%b hi=%h lo=%h expected busy=0 hi=%h lo=%h", t, busy, hi, lo, m_hi, m_lo);
      end
    end
  endtask

  task automatic test_div_zero;
    n_checks++;
    if (dz !== 1'b0) begin
      n_fail++;
      $display("FAIL dz_before: dz=%b expected 0", dz);
    end
    issue(OP_DIVU, 32'h7, 32'h0, 1'b0);
    for (int k = 1; k <= DIV_LAT; k++) begin
      n_checks++;
      if (busy !== 1'b1 || dz !== 1'b1 || hi !== m_hi || lo !== m_lo) begin
        n_fail++;
        $display("FAIL dz_run k=%0d: busy=%b dz=%b hi=%h lo=%h expected busy=1 dz=1 hi=%h lo=%h", k, busy, dz, hi, lo, m_hi, m_lo);
      end
      @(negedge clk);
    end
    m_hi = 32'h7; m_lo = 32'hFFFF_FFFF;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (busy !== 1'b0 || dz !== 1'b1 || hi !== m_hi || lo !== m_lo) begin
        n_fail++;
        $display("FAIL dz_done k=%0d: busy=%b dz=%b hi=%h lo=%h expected busy=0 dz=1 hi=%h lo=%h", k, busy, dz, hi, lo, m_hi, m_lo);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_op;
    issue(OP_DIV, 32'd100, 32'd7, 1'b0);
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || hi !== m_hi || lo !== m_lo) begin
      n_fail++;
      $display("FAIL rst_mid_pre: busy=%b hi=%h lo=%h expected busy=1 hi=%h lo=%h", busy, hi, lo, m_hi, m_lo);
    end
    #2 reset = 1'b0;
    #1;
    m_hi = 32'h0; m_lo = 32'h0;
    n_checks++;
    if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo || dz !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_async: busy=%b hi=%h lo=%h dz=%b expected all zero", busy, hi, lo, dz);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < DIV_LAT + 2; k++) begin
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo || dz !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_mid_after k=%0d: busy=%b hi=%h lo=%h dz=%b expected all zero", k, busy, hi, lo, dz);
      end
    end
  endtask

  task automatic test_param_sweep;
    s_op = OP_MULTU; s_a = 16'hFFFF; s_b = 16'hFFFF; s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    n_checks++;
    if (s_busy !== 1'b1 || s_hi !== 16'h0 || s_lo !== 16'h0) begin
      n_fail++;
      $display("FAIL sweep_mul_run: busy=%b hi=%h lo=%h expected busy=1 hi=0000 lo=0000", s_busy, s_hi, s_lo);
    end
    @(negedge clk);
    n_checks++;
    if (s_busy !== 1'b0 || s_hi !== 16'hFFFE || s_lo !== 16'h0001) begin
      n_fail++;
      $display("FAIL sweep_mul_done: busy=%b hi=%h lo=%h expected busy=0 hi=fffe lo=0001", s_busy, s_hi, s_lo);
    end
    s_op = OP_DIVU; s_a = 16'hFFFF; s_b = 16'h0010; s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    n_checks++;
    if (s_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL sweep_div_run: busy=%b expected 1", s_busy);
    end
    @(negedge clk);
    n_checks++;
    if (s_busy !== 1'b0 || s_hi !== 16'h000F || s_lo !== 16'h0FFF) begin
      n_fail++;
      $display("FAIL sweep_div_done: busy=%b hi=%h lo=%h expected busy=0 hi=000f lo=0fff", s_busy, s_hi, s_lo);
    end
  endtask

  initial begin
    start = 1'b0; cut = 1'b0; op = 3'd0; a = 32'h0; b = 32'h0;
    s_start = 1'b0; s_cut = 1'b0; s_op = 3'd0; s_a = 16'h0; s_b = 16'h0;
    m_hi = 32'h0; m_lo = 32'h0;
    test_reset();
    test_signed();
    test_cut();
    test_back_to_back();
    test_accumulate();
    test_div_zero();
    test_reset_mid_op();
    test_param_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
